// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Iterative restoring divider with ready/valid handshakes on both sides.
//   One quotient bit is resolved per cycle, MSB first. Results are
//   sign-corrected in a single fix-up cycle.
//   * is_signed = 0 : unsigned operands.
//   * is_signed = 1 : two's-complement operands. The result is truncating
//                     (C-style) when euclid = 0, and Euclidean (remainder
//                     never negative) when euclid = 1.
//   * divisor == 0  : quotient = all-ones, remainder = dividend, div_zero = 1.
//   * MIN / -1      : quotient = MIN (wrapped), remainder = 0, overflow = 1.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-high
//   in_valid   : dividend/divisor/mode are valid
//   in_ready   : divider is idle and accepts operands
//   dividend   : WIDTH-bit dividend
//   divisor    : WIDTH-bit divisor
//   is_signed  : 1 = two's-complement operands
//   euclid     : 1 = Euclidean result (signed only)
//   out_valid  : quotient/remainder/flags are valid
//   out_ready  : consumer takes the results
//   quotient   : WIDTH-bit quotient
//   remainder  : WIDTH-bit remainder
//   div_zero   : divisor was zero
//   overflow   : signed MIN / -1
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  input  logic             euclid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nxt;

  // Operation context captured at accept time.
  logic [WIDTH-1:0] rem;       // running partial remainder (starts as |dividend|)
  logic [WIDTH-1:0] b_mag;     // |divisor|
  logic [WIDTH-1:0] q_acc;     // unsigned quotient being built
  logic [CW-1:0]    idx;       // quotient bit resolved this CALC cycle
  logic             sign_a;
  logic             sign_b;
  logic             euc_mode;  // Euclidean correction enabled (signed only)
  logic             ovf_pend;  // operands were MIN / -1

  logic accept;
  assign accept = in_valid && in_ready;

  // Operand magnitudes. Signs are forced to 0 in unsigned mode, which makes
  // every sign correction in FIX a no-op without a separate mode bit.
  logic             in_sign_a, in_sign_b;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;
  assign in_sign_a = is_signed && dividend[WIDTH-1];
  assign in_sign_b = is_signed && divisor[WIDTH-1];
  assign in_mag_a  = in_sign_a ? -dividend : dividend;
  assign in_mag_b  = in_sign_b ? -divisor  : divisor;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (idx == '0) state_nxt = FIX;
      end
      FIX: begin
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Returning to IDLE here means in_ready only rises next cycle, so a
        // new operation can never be accepted in the handshake cycle.
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Restoring step: compared in 2*WIDTH bits so (b_mag << idx) never truncates.
  // When the subtraction is taken the shifted divisor is below 2^WIDTH, so the
  // low WIDTH bits are exact.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] shifted;
  logic               take;
  logic [WIDTH-1:0]   rem_sub;

  always_comb begin
    shifted = {{WIDTH{1'b0}}, b_mag} << idx;
    take    = ({{WIDTH{1'b0}}, rem} >= shifted);
    rem_sub = rem - shifted[WIDTH-1:0];
  end

  // ---------------------------------------------------------------------------
  // Sign correction of the unsigned quotient/remainder (modulo 2^WIDTH).
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] fix_q, fix_r;

  always_comb begin
    fix_q = (sign_a ^ sign_b) ? -q_acc : q_acc;
    fix_r = sign_a ? -rem : rem;
    // A negative dividend with non-zero remainder moves one step further
    // from zero so the remainder lands in [0, |b|).
    if (euc_mode && sign_a && (rem != '0)) begin
      fix_r = b_mag - rem;
      fix_q = sign_b ? (q_acc + ONE_W) : -(q_acc + ONE_W);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  // NOTE: the datapath is a handful of flops rather than a memory, so all of
  // it is reset; this also guarantees the outputs read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem       <= '0;
      b_mag     <= '0;
      q_acc     <= '0;
      idx       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      euc_mode  <= 1'b0;
      ovf_pend  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rem      <= in_mag_a;
            b_mag    <= in_mag_b;
            q_acc    <= '0;
            idx      <= CW'(WIDTH - 1);
            sign_a   <= in_sign_a;
            sign_b   <= in_sign_b;
            euc_mode <= is_signed && euclid;
            ovf_pend <= is_signed && (dividend == MIN_W) && (divisor == '1);
            // Divide-by-zero skips the iteration and publishes directly.
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
              overflow  <= 1'b0;
            end
          end
        end
        CALC: begin
          if (take) begin
            q_acc[idx] <= 1'b1;
            rem        <= rem_sub;
          end
          idx <= idx - 1'b1;
        end
        FIX: begin
          // MIN / -1 needs no special datapath: |MIN| / 1 wraps to MIN.
          quotient  <= fix_q;
          remainder <= fix_r;
          div_zero  <= 1'b0;
          overflow  <= ovf_pend;
        end
        DONE: begin
          // Results hold until the consumer takes them.
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Drives an 8-bit and a 16-bit seq_divider. Stimulus pushes the expected
//   result into a per-instance queue at the accept edge; a monitor per
//   instance pops and compares whenever an output handshake is about to occur.
//   Random expectations come from a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 8-bit instance
  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
  logic [7:0] dividend8 = '0, divisor8 = '0, quotient8, remainder8;
  logic       is_signed8 = 1'b0, euclid8 = 1'b0, div_zero8, overflow8;

  // 16-bit instance
  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0;
  logic [15:0] dividend16 = '0, divisor16 = '0, quotient16, remainder16;
  logic        is_signed16 = 1'b0, euclid16 = 1'b0, div_zero16, overflow16;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t sb8[$];
  exp_t sb16[$];

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .dividend  (dividend8),
    .divisor   (divisor8),
    .is_signed (is_signed8),
    .euclid    (euclid8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .quotient  (quotient8),
    .remainder (remainder8),
    .div_zero  (div_zero8),
    .overflow  (overflow8)
  );

  seq_divider #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .dividend  (dividend16),
    .divisor   (divisor16),
    .is_signed (is_signed16),
    .euclid    (euclid16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .quotient  (quotient16),
    .remainder (remainder16),
    .div_zero  (div_zero16),
    .overflow  (overflow16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] q, input logic [15:0] r,
                              input logic dz, input logic ovf);
    exp_t x;
    x.q = q; x.r = r; x.dz = dz; x.ovf = ovf;
    return x;
  endfunction

  // Reference model: integer division on mathematical values, then wrapped.
  function automatic exp_t ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                     input bit s, input bit e);
    longint one = 1;
    longint mask, ua, ub, sa, sb, q, r;
    exp_t   x;
    mask = (one << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    x    = mk('0, '0, 1'b0, 1'b0);
    if (ub == 0) begin
      q = mask; r = ua; x.dz = 1'b1;
    end else if (!s) begin
      q = ua / ub; r = ua % ub;
    end else begin
      sa = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
      sb = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
      if (sa == -(one << (w - 1)) && sb == -1) begin
        q = sa; r = 0; x.ovf = 1'b1;
      end else begin
        q = sa / sb; r = sa % sb;
        if (e && r < 0) begin
          if (sb > 0) begin q = q - 1; r = r + sb; end
          else        begin q = q + 1; r = r - sb; end
        end
      end
    end
    x.q = 16'(q & mask);
    x.r = 16'(r & mask);
    return x;
  endfunction

  // Random operands with a bias toward the interesting corners.
  task automatic gen_ops(input int w, output logic [15:0] a, output logic [15:0] b,
                         output bit s, output bit e);
    logic [15:0] mask;
    int          cat;
    mask = 16'hFFFF >> (16 - w);
    a    = 16'($urandom) & mask;
    b    = 16'($urandom) & mask;
    s    = 1'($urandom_range(0, 1));
    e    = 1'($urandom_range(0, 1));
    cat  = $urandom_range(0, 9);
    case (cat)
      1: a = '0;
      2: b = 16'd1;
      3: begin a = a >> (w / 2); b = b | (16'd1 << (w - 2)); end
      4: begin a = 16'd1 << (w - 1); b = mask; s = 1'b1; end
      5: b = '0;
      6: b = mask;
      7: b = 16'($urandom_range(1, 5));
      default: ;
    endcase
  endtask

  // ---------------------------------------------------------------------------
  // Monitors: a handshake happens at the next rising edge when both are high.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      if (sb8.size() == 0) check("unexpected_out8", {31'b0, out_valid8}, 32'd0);
      else begin
        exp_t x;
        x = sb8.pop_front();
        check("q8",   {24'b0, quotient8},  {24'b0, x.q[7:0]});
        check("r8",   {24'b0, remainder8}, {24'b0, x.r[7:0]});
        check("dz8",  {31'b0, div_zero8},  {31'b0, x.dz});
        check("ovf8", {31'b0, overflow8},  {31'b0, x.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid16 && out_ready16) begin
      if (sb16.size() == 0) check("unexpected_out16", {31'b0, out_valid16}, 32'd0);
      else begin
        exp_t x;
        x = sb16.pop_front();
        check("q16",   {16'b0, quotient16},  {16'b0, x.q});
        check("r16",   {16'b0, remainder16}, {16'b0, x.r});
        check("dz16",  {31'b0, div_zero16},  {31'b0, x.dz});
        check("ovf16", {31'b0, overflow16},  {31'b0, x.ovf});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit s, input bit e,
                        input bit track, input exp_t x);
    dividend8 = a; divisor8 = b; is_signed8 = s; euclid8 = e; in_valid8 = 1'b1;
    for (int k = 0; k < 200 && !in_ready8; k++) begin @(posedge clk); #1; end
    if (!in_ready8) begin
      check("accept8_timeout", {31'b0, in_ready8}, 32'd1);
      in_valid8 = 1'b0;
      return;
    end
    @(posedge clk);
    if (track) sb8.push_back(x);
    #1;
    in_valid8 = 1'b0;
    // Operands after acceptance must not disturb the operation.
    dividend8 = 8'($urandom); divisor8 = 8'($urandom);
    is_signed8 = 1'($urandom); euclid8 = 1'($urandom);
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input bit s, input bit e,
                         input exp_t x);
    dividend16 = a; divisor16 = b; is_signed16 = s; euclid16 = e; in_valid16 = 1'b1;
    for (int k = 0; k < 200 && !in_ready16; k++) begin @(posedge clk); #1; end
    if (!in_ready16) begin
      check("accept16_timeout", {31'b0, in_ready16}, 32'd1);
      in_valid16 = 1'b0;
      return;
    end
    @(posedge clk);
    sb16.push_back(x);
    #1;
    in_valid16 = 1'b0;
    dividend16 = 16'($urandom); divisor16 = 16'($urandom);
    is_signed16 = 1'($urandom); euclid16 = 1'($urandom);
  endtask

  // Latency counts the accepting edge as edge 1.
  task automatic wait_out8(output int lat);
    lat = 1;
    while (!out_valid8 && lat < 200) begin @(posedge clk); #1; lat++; end
    check("out8_timeout", {31'b0, out_valid8}, 32'd1);
  endtask

  task automatic wait_out16(output int lat);
    lat = 1;
    while (!out_valid16 && lat < 200) begin @(posedge clk); #1; lat++; end
    check("out16_timeout", {31'b0, out_valid16}, 32'd1);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit s, input bit e,
                      input logic [7:0] q, input logic [7:0] r, input bit dz, input bit ovf,
                      input int exp_lat, input string name);
    int lat;
    out_ready8 = 1'b1;
    issue8(a, b, s, e, 1'b1, mk({8'b0, q}, {8'b0, r}, dz, ovf));
    wait_out8(lat);
    check({name, "_lat"}, lat, exp_lat);
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          lat;
    logic [15:0] a, b;
    bit          s, e;
    exp_t        x;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready8",  {31'b0, in_ready8},  32'd1);
    check("rst_out_valid8", {31'b0, out_valid8}, 32'd0);
    check("rst_q8",         {24'b0, quotient8},  32'd0);
    check("rst_r8",         {24'b0, remainder8}, 32'd0);
    check("rst_flags8",     {30'b0, div_zero8, overflow8}, 32'd0);
    check("rst_in_ready16", {31'b0, in_ready16},  32'd1);
    check("rst_q16",        {16'b0, quotient16},  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Unsigned 200/7 with backpressure; a second request waits in DONE.
    out_ready8 = 1'b0;
    issue8(8'd200, 8'd7, 1'b0, 1'b0, 1'b1, mk(16'd28, 16'd4, 1'b0, 1'b0));
    wait_out8(lat);
    check("lat_200_7", lat, 10);
    dividend8 = 8'd50; divisor8 = 8'd5; is_signed8 = 1'b0; euclid8 = 1'b0; in_valid8 = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_out_valid", {31'b0, out_valid8}, 32'd1);
      check("bp_in_ready",  {31'b0, in_ready8},  32'd0);
      check("bp_q",         {24'b0, quotient8},  32'd28);
      check("bp_r",         {24'b0, remainder8}, 32'd4);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    check("handshake_in_ready",  {31'b0, in_ready8},  32'd1);
    check("handshake_out_valid", {31'b0, out_valid8}, 32'd0);
    check("hold_after_hs_q",     {24'b0, quotient8},  32'd28);
    issue8(8'd50, 8'd5, 1'b0, 1'b0, 1'b1, mk(16'd10, 16'd0, 1'b0, 1'b0));
    wait_out8(lat);
    check("lat_50_5", lat, 10);
    @(posedge clk); #1;

    // Signed truncating and Euclidean cases.
    run8(8'hF9, 8'd2,  1'b1, 1'b0, 8'hFD, 8'hFF, 1'b0, 1'b0, 10, "trunc_m7_2");
    run8(8'hF9, 8'd2,  1'b1, 1'b1, 8'hFC, 8'd1,  1'b0, 1'b0, 10, "euc_m7_2");
    run8(8'hF9, 8'hFE, 1'b1, 1'b1, 8'd4,  8'd1,  1'b0, 1'b0, 10, "euc_m7_m2");
    run8(8'd7,  8'hFE, 1'b1, 1'b1, 8'hFD, 8'd1,  1'b0, 1'b0, 10, "euc_7_m2");
    // Overflow and divide-by-zero.
    run8(8'h80, 8'hFF, 1'b1, 1'b0, 8'h80, 8'd0,  1'b0, 1'b1, 10, "ovf");
    run8(8'h35, 8'd0,  1'b1, 1'b0, 8'hFF, 8'h35, 1'b1, 1'b0, 1,  "dz_signed");
    run8(8'h35, 8'd0,  1'b0, 1'b1, 8'hFF, 8'h35, 1'b1, 1'b0, 1,  "dz_unsigned");

    // Reset in the middle of CALC abandons the operation.
    out_ready8 = 1'b1;
    issue8(8'd100, 8'd7, 1'b0, 1'b0, 1'b0, mk('0, '0, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", {31'b0, out_valid8}, 32'd0);
    check("midrst_in_ready",  {31'b0, in_ready8},  32'd1);
    check("midrst_q",         {24'b0, quotient8},  32'd0);
    check("midrst_r",         {24'b0, remainder8}, 32'd0);
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid8) check("midrst_spurious_valid", {31'b0, out_valid8}, 32'd0);
    end
    run8(8'd100, 8'd10, 1'b0, 1'b0, 8'd10, 8'd0, 1'b0, 1'b0, 10, "after_rst");

    // Random sweep, 8-bit.
    for (int i = 0; i < 250; i++) begin
      gen_ops(8, a, b, s, e);
      x = ref_model(8, a, b, s, e);
      out_ready8 = 1'($urandom_range(0, 1));
      issue8(a[7:0], b[7:0], s, e, 1'b1, x);
      wait_out8(lat);
      check("rnd8_lat", lat, (b[7:0] == 8'd0) ? 1 : 10);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
    end

    // Random sweep, 16-bit.
    for (int i = 0; i < 200; i++) begin
      gen_ops(16, a, b, s, e);
      x = ref_model(16, a, b, s, e);
      out_ready16 = 1'($urandom_range(0, 1));
      issue16(a, b, s, e, x);
      wait_out16(lat);
      check("rnd16_lat", lat, (b == 16'd0) ? 1 : 18);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      out_ready16 = 1'b1;
      @(posedge clk); #1;
      out_ready16 = 1'b0;
    end

    repeat (4) @(posedge clk);
    #1;
    check("sb8_drained",  sb8.size(),  32'd0);
    check("sb16_drained", sb16.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised successor to the calculator's fixed 32-bit restoring divider.
- Iterative restoring divider, WIDTH bits, with a ready/valid handshake on both input and output.
- Adds: signed/unsigned select; truncating or Euclidean result mode; divide-by-zero and overflow flags; synchronous reset; output hold under backpressure.
- Used by the calculator core for the div and mod operations, and reusable elsewhere.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4)

Ports:
clk  in  1  single clock; all state changes on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operands and mode valid
in_ready  out  1  block can accept operands
dividend  in  WIDTH  dividend
divisor  in  WIDTH  divisor
is_signed  in  1  1 = two's-complement operands, 0 = unsigned
euclid  in  1  1 = Euclidean (remainder >= 0), 0 = truncating (C-style); ignored when is_signed = 0
out_valid  out  1  results valid
out_ready  in  1  consumer takes results
quotient  out  WIDTH  quotient
remainder  out  WIDTH  remainder
div_zero  out  1  divisor was 0
overflow  out  1  signed MIN / -1

Behaviour:
- Interface: one clock (clk); reset is synchronous, active-high (rst).
- Reset:
  - State -> IDLE; in_ready = 1; out_valid = 0.
  - quotient, remainder, div_zero, overflow = 0.
  - rst mid-operation abandons the operation; no out_valid is produced for it.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch the following:
    - magnitudes |dividend| and |divisor| (raw values when unsigned);
    - sign_a, sign_b;
    - mode bits;
    - the original dividend.
  - Bit counter <- WIDTH-1.
  - divisor == 0 -> DONE at next edge.
  - Otherwise -> CALC.
- CALC:
  - One quotient bit per cycle, MSB first: if rem >= (divisor_mag << idx), then q[idx] = 1 and rem -= (divisor_mag << idx).
  - Compare in 2*WIDTH bits so the shift never truncates.
  - Exactly WIDTH cycles, then -> FIX.
- FIX (1 cycle): sign correction of unsigned results qu, ru.
  - Unsigned: q = qu, r = ru.
  - Signed truncating:
    - q = (sign_a ^ sign_b) ? -qu : qu.
    - r = sign_a ? -ru : ru.
  - Signed Euclidean, ru == 0 or !sign_a: same as truncating.
  - Signed Euclidean, sign_a && ru != 0:
    - r = |b| - ru.
    - q = sign_b ? qu + 1 : -(qu + 1).
  - All arithmetic is modulo 2^WIDTH.
  - -> DONE.
- Overflow: is_signed, dividend = 100..0, divisor = all-ones.
  - quotient = 100..0 (wrapped), remainder = 0, overflow = 1.
- Divide by zero: quotient = all-ones, remainder = dividend (raw), div_zero = 1, overflow = 0.
- DONE:
  - out_valid = 1; in_ready = 0.
  - Results and flags are stable while out_valid && !out_ready.
  - On out_ready -> IDLE. in_ready rises the following cycle; no same-cycle re-accept.
- Latency, counted as edges from the accepting edge to out_valid high:
  - WIDTH+2 normally;
  - 1 for divide-by-zero.
- Results remain on outputs after handshake until the next FIX/DONE update.
- Operand inputs are ignored outside IDLE.
- in_valid dropping mid-operation has no effect.

Test Plan:
- WIDTH=8, unsigned, 200 / 7 -> q=28, r=4, flags 0; out_valid exactly 10 edges after accept.
- Signed trunc -7/2 -> q=-3 (0xFD), r=-1 (0xFF). Signed Euclid:
  - -7/2 -> q=-4, r=1;
  - -7/-2 -> q=4, r=1;
  - 7/-2 -> q=-3, r=1.
- Signed -128 / -1 -> q=0x80, r=0, overflow=1. Then 0x35 / 0 (either mode) -> q=0xFF, r=0x35, div_zero=1, out_valid 1 edge after accept.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs constant, in_ready=0; a new in_valid is ignored until in_ready returns.
- Assert rst during CALC -> next cycle out_valid=0, in_ready=1, outputs 0. A following 100/10 -> q=10, r=0.
- Random sweep, WIDTH=8 and WIDTH=16, all four mode combinations, against a reference model; include 0 dividend, divisor 1, and divisor > dividend.
